reverse_complement: RTL and testbench

REVERSE_COMPLEMENT -- requirements
Module: reverse_complement

---
 rtl/reverse_complement_if.sv | 22 ++
 rtl/reverse_complement.sv | 104 ++++++++++
 tb/tb_reverse_complement.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/reverse_complement_if.sv
// rtl/reverse_complement_if.sv - base stream handshake bundle for reverse_complement
interface reverse_complement_if;
    logic       in_valid;
    logic       in_ready;
    logic [0:7] in_base;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [0:7] out_base;
    logic       out_last;
    logic       overflow;

    modport master (
        output in_valid, in_base, in_last, out_ready,
        input  in_ready, out_valid, out_base, out_last, overflow
    );

    modport slave (
        input  in_valid, in_base, in_last, out_ready,
        output in_ready, out_valid, out_base, out_last, overflow
    );
endinterface

// File: rtl/reverse_complement.sv
// rtl/reverse_complement.sv - LIFO-based DNA reverse complement; RC_LOWERCASE_EN adds lowercase a/t/g/c support
module reverse_complement #(
    parameter int DEPTH = 64
) (
    input logic                  clock,
    input logic                  reset,
    reverse_complement_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic          overflow;
    logic [0:7]    mem [DEPTH];
    logic          push;
    logic          pop;
    logic          full_next;
    logic [AW-1:0] top_idx;
    logic          in_ready;
    logic          out_valid;
    logic          out_last;
    logic [0:7]    out_base;

    function automatic logic [0:7] complement(input logic [0:7] b);
        logic [0:7] r;
        case (b)
            8'h41:   r = 8'h54;
            8'h54:   r = 8'h41;
            8'h47:   r = 8'h43;
            8'h43:   r = 8'h47;
`ifdef RC_LOWERCASE_EN
            8'h61:   r = 8'h74;
            8'h74:   r = 8'h61;
            8'h67:   r = 8'h63;
            8'h63:   r = 8'h67;
`endif
            default: r = 8'h4E;
        endcase
        return r;
    endfunction

    assign top_idx   = AW'(count - CW'(1));
    assign full_next = (count == CW'(DEPTH - 1));

    always_comb begin
        state_next = state;
        push       = 1'b0;
        pop        = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_base   = 8'h02;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                push     = bus.in_valid;
                if (push && (bus.in_last || full_next))
                    state_next = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = (count == CW'(1));
                out_base  = complement(mem[top_idx]);
                pop       = bus.out_ready;
                if (pop && out_last)
                    state_next = FILL;
            end
            default: state_next = FILL;
        endcase
    end

    // Overflow is rewritten on every push: the first push of a sequence clears it,
    // and only the push that fills the LIFO without in_last can set it again.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= FILL;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            if (push) begin
                count    <= count + CW'(1);
                overflow <= full_next && !bus.in_last;
            end else if (pop) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[count[AW-1:0]] <= bus.in_base;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;
    assign bus.out_base  = out_base;
    assign bus.overflow  = overflow;
endmodule

// File: tb/tb_reverse_complement.sv
// tb/tb_reverse_complement.sv - scoreboard bench for reverse_complement (DEPTH=4)
module tb_reverse_complement;
    logic clock;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [8:0] sb[$];
    logic       held_v = 1'b0;
    logic [7:0] held_b;
    logic       held_l;

    reverse_complement_if bus();

    reverse_complement #(.DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input logic [7:0] b, input logic last);
        sb.push_back({b, last});
    endtask

    task automatic push(input logic [7:0] b, input logic last);
        int n = 0;
        bus.in_base  = b;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        check("push_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic drain(input logic toggle);
        int c = 0;
        while (sb.size() > 0 && c < 200) begin
            bus.out_ready = toggle ? ~c[0] : 1'b1;
            @(posedge clock); #1;
            c++;
        end
        bus.out_ready = 1'b0;
        check("drain_empty", sb.size(), 0);
    endtask

    always @(negedge clock) begin
        logic [8:0] e;
        if (!reset) begin
            held_v = 1'b0;
        end else if (bus.out_valid) begin
            if (held_v) begin
                check("stall_base", {24'd0, bus.out_base}, {24'd0, held_b});
                check("stall_last", {31'd0, bus.out_last}, {31'd0, held_l});
            end
            if (bus.out_ready) begin
                held_v = 1'b0;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out got=%0h want=none", bus.out_base);
                end else begin
                    e = sb.pop_front();
                    check("out_base", {24'd0, bus.out_base}, {24'd0, e[8:1]});
                    check("out_last", {31'd0, bus.out_last}, {31'd0, e[0]});
                end
            end else begin
                held_v = 1'b1;
                held_b = bus.out_base;
                held_l = bus.out_last;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    initial begin
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_base   = 8'h00;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_last",  {31'd0, bus.out_last},  32'd0);
        check("rst_out_base",  {24'd0, bus.out_base},  32'h02);
        check("rst_overflow",  {31'd0, bus.overflow},  32'd0);
        reset = 1'b1;
        check("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // in_last without in_valid must be ignored
        bus.in_last = 1'b1;
        @(posedge clock); #1;
        bus.in_last = 1'b0;
        check("idle_last_ready", {31'd0, bus.in_ready},  32'd1);
        check("idle_last_valid", {31'd0, bus.out_valid}, 32'd0);

        // AACG -> CGTT
        expect_out("C", 0); expect_out("G", 0); expect_out("T", 0); expect_out("T", 1);
        push("A", 0); push("A", 0); push("C", 0); push("G", 1);
        check("aacg_latency", {31'd0, bus.out_valid}, 32'd1);
        check("aacg_overflow", {31'd0, bus.overflow}, 32'd0);
        drain(0);

        // single base
        expect_out("C", 1);
        push("G", 1);
        check("single_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b1;
        @(posedge clock); #1;
        bus.out_ready = 1'b0;
        check("single_ready_back", {31'd0, bus.in_ready},  32'd1);
        check("single_valid_off",  {31'd0, bus.out_valid}, 32'd0);

        // overflow at DEPTH=4
        expect_out("A", 0); expect_out("C", 0); expect_out("G", 0); expect_out("T", 1);
        push("A", 0); push("C", 0); push("G", 0); push("T", 0);
        check("ovf_set",   {31'd0, bus.overflow},  32'd1);
        check("ovf_drain", {31'd0, bus.out_valid}, 32'd1);
        drain(0);
        check("ovf_hold", {31'd0, bus.overflow}, 32'd1);
        expect_out("T", 1);
        push("A", 1);
        check("ovf_clear", {31'd0, bus.overflow}, 32'd0);
        drain(0);

        // unknown code and stalled output
        expect_out("G", 0); expect_out("N", 0); expect_out("T", 1);
        push("A", 0); push("X", 0); push("C", 1);
        drain(1);

        // reset mid-drain
        expect_out("C", 0);
        push("A", 0); push("C", 0); push("G", 1);
        bus.out_ready = 1'b1;
        @(posedge clock); #1;
        bus.out_ready = 1'b0;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_base",  {24'd0, bus.out_base},  32'h02);
        check("mid_rst_last",  {31'd0, bus.out_last},  32'd0);
        check("mid_rst_ready", {31'd0, bus.in_ready},  32'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        check("mid_rst_popped", sb.size(), 0);
        expect_out("A", 1);
        push("T", 1);
        drain(0);

        // lowercase
`ifdef RC_LOWERCASE_EN
        expect_out("g", 0); expect_out("t", 1);
`else
        expect_out("N", 0); expect_out("N", 1);
`endif
        push("a", 0); push("c", 1);
        drain(0);

        repeat (3) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
